// File: rtl/ocpl_addsub_ctrl_pkg.sv
// Shared types and constants for the ones'-complement add/subtract sequencer.
// The FSM state encoding, the op codes and the default operand width live here.
package ocpl_pkg;

    localparam int DEFAULT_WIDTH = 4;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        COMPL = 3'd2,
        ADD   = 3'd3,
        EAC   = 3'd4,
        DONE  = 3'd5
    } state_t;

endpackage

// File: rtl/ocpl_addsub_ctrl_if.sv
// Request/result handshake plus the link to the external complementer.
// The master side issues requests and supplies cpl_out; the slave side is the sequencer.
interface ocpl_addsub_ctrl_if
    import ocpl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic             start;
    logic             op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] cpl_inp;
    logic             cpl_en;
    logic [WIDTH-1:0] cpl_out;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             ovf;
    logic             negz;

    modport master (
        output start, op, a, b, cpl_out,
        input  cpl_inp, cpl_en, busy, done, result, ovf, negz
    );

    modport slave (
        input  start, op, a, b, cpl_out,
        output cpl_inp, cpl_en, busy, done, result, ovf, negz
    );

endinterface

// File: rtl/ocpl_eac_adder.sv
// Plain WIDTH-bit adder exposing its carry-out; the carry is folded back in
// one stage later by the sequencer (end-around carry).
module ocpl_eac_adder
    import ocpl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    assign {cout, sum} = {1'b0, x} + {1'b0, y};

endmodule

// File: rtl/ocpl_addsub_ctrl.sv
// Multi-cycle ones'-complement add/subtract sequencer: borrows an external
// complementer for B, adds with end-around carry, reports result/ovf/negz.
module ocpl_addsub_ctrl
    import ocpl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                clk,
    input  logic                rst,
    ocpl_addsub_ctrl_if.slave   bus
);

    localparam int MSB = WIDTH - 1;

    state_t           state;
    state_t           next_state;

    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             op_r;
    logic [WIDTH-1:0] sum_r;
    logic             carry_r;

    logic [WIDTH-1:0] cpl_inp_r;
    logic             cpl_en_r;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] result_r;
    logic             ovf_r;
    logic             negz_r;

    logic             busy_d;
    logic             done_d;
    logic             capture;

    logic [WIDTH-1:0] add_sum;
    logic             add_cout;
    logic [WIDTH-1:0] eac_result;

    ocpl_eac_adder #(.WIDTH(WIDTH)) u_eac_adder (
        .x    (a_r),
        .y    (b_r),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // sum_r + 1 cannot overflow when carry_r is set, so one fold is enough
    assign eac_result = sum_r + {{(WIDTH-1){1'b0}}, carry_r};

    // NOTE: state and datapath registers use non-blocking assignments so every
    // flop samples the values that existed before the clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // NOTE: next_state gets a default first so no path through the case
    // leaves it unassigned and infers a latch.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (bus.start) next_state = LOAD;
            LOAD:    next_state = COMPL;
            COMPL:   next_state = ADD;
            ADD:     next_state = EAC;
            EAC:     next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // busy/done are registered from the state the FSM is about to enter/leave
    always_comb begin
        capture = (state == IDLE) && bus.start;
        busy_d  = (next_state != IDLE);
        done_d  = (state == DONE);
    end

    // NOTE: every register here, operands included, is cleared by reset so an
    // aborted operation leaves no stale data behind.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r       <= '0;
            b_r       <= '0;
            op_r      <= OP_ADD;
            sum_r     <= '0;
            carry_r   <= 1'b0;
            cpl_inp_r <= '0;
            cpl_en_r  <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            result_r  <= '0;
            ovf_r     <= 1'b0;
            negz_r    <= 1'b0;
        end else begin
            busy_r <= busy_d;
            done_r <= done_d;
            case (state)
                IDLE: begin
                    if (capture) begin
                        a_r  <= bus.a;
                        b_r  <= bus.b;
                        op_r <= bus.op;
                    end
                end
                LOAD: begin
                    cpl_inp_r <= b_r;
                    cpl_en_r  <= op_r;
                end
                COMPL: begin
                    b_r <= bus.cpl_out;
                end
                ADD: begin
                    sum_r   <= add_sum;
                    carry_r <= add_cout;
                end
                EAC: begin
                    result_r <= eac_result;
                    ovf_r    <= (a_r[MSB] == b_r[MSB]) && (eac_result[MSB] != a_r[MSB]);
                    negz_r   <= &eac_result;
                end
                DONE: begin
                    cpl_inp_r <= '0;
                    cpl_en_r  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.cpl_inp = cpl_inp_r;
    assign bus.cpl_en  = cpl_en_r;
    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.result  = result_r;
    assign bus.ovf     = ovf_r;
    assign bus.negz    = negz_r;

endmodule

// File: tb/tb_ocpl_addsub_ctrl.sv
// Scoreboard bench for ocpl_addsub_ctrl: drivers push expected results, a
// negedge monitor pops them whenever done is seen. The complementer is emulated here.
module tb_ocpl_addsub_ctrl;

    localparam int W = 4;

    typedef struct {
        logic [W-1:0] res;
        logic         ovf;
        logic         negz;
        int           cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    logic prev_done = 1'b0;

    ocpl_addsub_ctrl_if #(.WIDTH(W)) bus ();

    ocpl_addsub_ctrl #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // external combinational ones'-complementer
    assign bus.cpl_out = bus.cpl_en ? ~bus.cpl_inp : bus.cpl_inp;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ones'-complement reference: complement B for subtract, add, fold the carry back
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic op);
        logic [W-1:0] bb;
        logic [W:0]   s;
        logic [W-1:0] r;
        exp_t         e;
        bb = op ? ~b : b;
        s  = {1'b0, a} + {1'b0, bb};
        r  = s[W-1:0] + {{(W-1){1'b0}}, s[W]};
        e.res  = r;
        e.ovf  = (a[W-1] == bb[W-1]) && (r[W-1] != a[W-1]);
        e.negz = (r == {W{1'b1}});
        e.cyc  = 0;
        return e;
    endfunction

    // monitor: every done pulse must match the oldest expected response
    always @(negedge clk) begin
        if (rst) begin
            prev_done <= 1'b0;
        end else begin
            if (bus.done) begin
                check("done_single_cycle", {31'b0, prev_done}, 32'd0);
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done at cycle %0d, expected no done", cyc);
                end else begin : pop
                    exp_t e;
                    e = sb.pop_front();
                    check("result", {28'b0, bus.result}, {28'b0, e.res});
                    check("ovf", {31'b0, bus.ovf}, {31'b0, e.ovf});
                    check("negz", {31'b0, bus.negz}, {31'b0, e.negz});
                    check("latency_cycle", cyc, e.cyc);
                end
            end
            prev_done <= bus.done;
        end
    end

    task automatic wait_done(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (bus.done) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no done in 20 cycles, expected done", name);
        end
    endtask

    task automatic push_exp(input logic [W-1:0] r, input logic o, input logic n);
        exp_t e;
        e.res  = r;
        e.ovf  = o;
        e.negz = n;
        e.cyc  = cyc + 5;
        sb.push_back(e);
    endtask

    // one operation with start pulsed; operands scrambled after sampling
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic op,
                          input logic [W-1:0] er, input logic eo, input logic en,
                          input bit detail);
        @(negedge clk);
        bus.a     = a;
        bus.b     = b;
        bus.op    = op;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a     = ~a;
        bus.b     = ~b;
        bus.op    = ~op;
        push_exp(er, eo, en);
        if (detail) begin
            check("busy_after_start", {31'b0, bus.busy}, 32'd1);
            @(negedge clk);
            check("cpl_en_load", {31'b0, bus.cpl_en}, 32'd0);
            @(negedge clk);
            check("cpl_en_compl", {31'b0, bus.cpl_en}, {31'b0, op});
            check("cpl_inp_compl", {28'b0, bus.cpl_inp}, {28'b0, b});
        end
        wait_done("run_op");
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, {31'b0, bus.busy}, 32'd0);
        check({tag, "_done"}, {31'b0, bus.done}, 32'd0);
        check({tag, "_result"}, {28'b0, bus.result}, 32'd0);
        check({tag, "_ovf"}, {31'b0, bus.ovf}, 32'd0);
        check({tag, "_negz"}, {31'b0, bus.negz}, 32'd0);
        check({tag, "_cpl_inp"}, {28'b0, bus.cpl_inp}, 32'd0);
        check({tag, "_cpl_en"}, {31'b0, bus.cpl_en}, 32'd0);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.op    = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // directed vectors, hand-computed
        run_op(4'b0011, 4'b0010, 1'b0, 4'b0101, 1'b0, 1'b0, 1'b1);
        run_op(4'b0101, 4'b0011, 1'b1, 4'b0010, 1'b0, 1'b0, 1'b1);
        run_op(4'b0011, 4'b0101, 1'b1, 4'b1101, 1'b0, 1'b0, 1'b1);
        run_op(4'b0111, 4'b0001, 1'b0, 4'b1000, 1'b1, 1'b0, 1'b1);
        run_op(4'b0000, 4'b0000, 1'b1, 4'b1111, 1'b0, 1'b1, 1'b1);

        // start held high: back-to-back ops, operands changed while busy
        @(negedge clk);
        bus.a     = 4'b0001;
        bus.b     = 4'b0001;
        bus.op    = 1'b0;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        push_exp(4'b0010, 1'b0, 1'b0);
        bus.a = 4'b0111;
        bus.b = 4'b0111;
        wait_done("held_first");
        bus.a  = 4'b1110;
        bus.b  = 4'b0001;
        bus.op = 1'b0;
        @(posedge clk);
        #1;
        push_exp(4'b1111, 1'b0, 1'b1);
        bus.a  = 4'b0110;
        bus.b  = 4'b1001;
        bus.op = 1'b1;
        wait_done("held_second");
        bus.start = 1'b0;
        @(negedge clk);
        check("busy_after_release", {31'b0, bus.busy}, 32'd0);

        // reset pulsed during ADD aborts without a done
        @(negedge clk);
        bus.a     = 4'b0011;
        bus.b     = 4'b0010;
        bus.op    = 1'b0;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("abort");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        check("busy_after_abort", {31'b0, bus.busy}, 32'd0);
        run_op(4'b0100, 4'b0001, 1'b1, 4'b0011, 1'b0, 1'b0, 1'b1);

        // exhaustive sweep against the reference model
        for (int op = 0; op < 2; op++) begin
            for (int ia = 0; ia < 16; ia++) begin
                for (int ib = 0; ib < 16; ib++) begin
                    exp_t e;
                    e = model(ia[W-1:0], ib[W-1:0], op[0]);
                    run_op(ia[W-1:0], ib[W-1:0], op[0], e.res, e.ovf, e.negz, 1'b0);
                end
            end
        end

        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        check("scoreboard_drained", sb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ocpl_addsub_ctrl.md
Name: ocpl_addsub_ctrl

Overview:
Multi-cycle sequencer that performs signed ones'-complement add/subtract on WIDTH-bit operands. It uses an external combinational ones'-complementer (data in, control bit, data out) as a shared datapath resource. The controller loads operands and drives the complementer with B and the subtract flag, then registers its output. It adds the result to A with end-around carry and reports the result, the signed overflow flag and the negative-zero flag through a start/done handshake.

Parameters:
WIDTH, 4, operand/result width in bits (min 2)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
start  in  1  request; sampled only in IDLE
op  in  1  0 = A+B, 1 = A-B; sampled with start
a  in  WIDTH  operand A (ones'-complement signed); sampled with start
b  in  WIDTH  operand B; sampled with start
cpl_inp  out  WIDTH  data to external complementer
cpl_en  out  1  complement control to external complementer
cpl_out  in  WIDTH  complementer result (combinational from cpl_inp/cpl_en)
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse; result/ovf/negz valid
result  out  WIDTH  sum/difference; held until next start
ovf  out  1  signed overflow of last operation
negz  out  1  result is all ones (negative zero)

Behaviour:
- Reset (async, any state): state=IDLE. busy, done, ovf and negz = 0. result, cpl_inp and cpl_en = 0. Internal regs a_r, b_r, op_r and sum_r = 0.
- All outputs registered; FSM states IDLE, LOAD, COMPL, ADD, EAC, DONE.
- IDLE: on start=1 capture a_r=a, b_r=b, op_r=op; next LOAD. start=0 stays IDLE.
- LOAD: cpl_inp<=b_r, cpl_en<=op_r; next COMPL. Signals stay stable through COMPL.
- COMPL: b_r<=cpl_out (B, or ~B when op_r=1); next ADD.
- ADD: {c,sum_r}<=a_r+b_r computed at WIDTH+1 bits; carry c kept in carry_r; next EAC.
- EAC: result<=sum_r+carry_r (end-around carry, truncated to WIDTH).
- EAC flag rules:
  - ovf<=(a_r[MSB]==b_r[MSB]) && (final result MSB != a_r[MSB]).
  - negz<=(final result == all ones).
  - Next state DONE.
- DONE: done=1 for exactly this cycle; cpl_en<=0, cpl_inp<=0; next IDLE unconditionally.
- Latency: start sampled at edge k; done high in the cycle following edge k+5. Minimum spacing between accepted starts is 6 cycles. start may be held high continuously; a new operation begins in the cycle after DONE.
- start, a, b and op are ignored while busy=1; operands are only sampled in IDLE.
- result, ovf and negz hold their values from DONE until the EAC of the next operation.
- EAC carry never propagates twice: sum_r+1 cannot carry out when carry_r=1.
- Negative zero (all ones) is returned unnormalised and flagged by negz.
- rst asserted mid-operation aborts immediately; done is never emitted for the aborted operation.

Decomposition:
- Package ocpl_pkg holds:
  - state enum (IDLE..DONE, 3-bit encoding)
  - OP_ADD=1'b0, OP_SUB=1'b1
  - default WIDTH constant
- One natural sub-module: ocpl_eac_adder. It is a combinational WIDTH-bit adder with carry-out, instantiated in the ADD stage.
- The external complementer is not instantiated inside; the top-level test harness wires it to cpl_inp/cpl_en/cpl_out.

Test Plan:
- Add: a=0011, b=0010, op=0 -> done 6 cycles after start; result=0101, ovf=0, negz=0; cpl_en=0 during LOAD/COMPL.
- Subtract with end-around carry: a=0101, b=0011, op=1 -> cpl_out=1100, ADD gives carry 1/sum 0001; result=0010, ovf=0.
- Negative result: a=0011, b=0101, op=1 -> result=1101 (-2), ovf=0, negz=0.
- Overflow and negative zero:
  - a=0111, b=0001, op=0 -> result=1000, ovf=1.
  - a=0000, b=0000, op=1 -> result=1111, negz=1, ovf=0.
- Handshake and reset:
  - start held high and operands changed while busy -> changed operands ignored; back-to-back ops complete with done exactly one cycle each.
  - rst pulsed during ADD -> all outputs 0 immediately, no done; the next start completes normally.
- Exhaustive: all 16x16x2 operand/op combinations checked against a reference ones'-complement model. The bench emulates the complementer.
